instr_fetch_unit: RTL

- Fetch stage directly upstream of the control unit in the CPU.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small prefetch FIFO and presents the head instruction to decode, split into opCode/funct3/funct7 fields.
- Accepts branch/jump redirects, flushing the buffer and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int          XLEN_DEF = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Instruction field positions used for the decode split.
   localparam int OPC_LSB = 0;
   localparam int F3_LSB  = 12;
   localparam int F7_LSB  = 25;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [31:0]         inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, inst} entries with push/pop/flush.
// Flush wins over push and pop; storage is left unreset because the
// pointers and occupancy alone define what is valid.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_entry_t           push_entry,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr] <= push_entry;
   end

   // The issue rule reserves a slot for every outstanding request.
   assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, in-order memory requests,
// prefetch buffering and redirect handling with in-flight response drop.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetched/dropped counters.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [6:0]      opCode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_dropped
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redirect_aligned;
   logic [CW-1:0]   outstanding, out_nxt;
   logic [CW-1:0]   drop_cnt, drop_nxt;
   logic [CW-1:0]   occ;
   logic [CW:0]     in_use;
   logic            req_fire;
   logic            rsp_drop;
   logic            rsp_keep;
   logic            pop_fire;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    fifo_head;
   fetch_entry_t    fifo_in;

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
   assign in_use   = {1'b0, occ} + {1'b0, outstanding};
   assign req_fire = imem_req_valid && imem_req_ready;
   // A response arriving with a redirect is lost along with the buffer.
   assign rsp_drop = imem_rsp_valid && ((drop_cnt != '0) || redirect_valid);
   assign rsp_keep = imem_rsp_valid && !rsp_drop && !fifo_full;
   assign pop_fire = inst_valid && inst_ready && !redirect_valid;
   assign out_nxt  = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
   assign fifo_in  = '{pc: XLEN_DEF'(resp_pc), inst: imem_rsp_data};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rsp_keep),
      .push_entry (fifo_in),
      .pop        (pop_fire),
      .flush      (redirect_valid),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (occ)
   );

   assign imem_req_addr = fetch_pc;
   assign inst_valid    = !fifo_empty;
   assign inst_data     = fifo_empty ? NOP_INST : fifo_head.inst;
   assign inst_pc       = fifo_empty ? '0 : XLEN'(fifo_head.pc);
   assign opCode        = inst_data[OPC_LSB +: 7];
   assign funct3        = inst_data[F3_LSB +: 3];
   assign funct7        = inst_data[F7_LSB +: 7];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // Next state, drop counter update and request issue.
   always_comb begin
      state_nxt      = state;
      drop_nxt       = drop_cnt;
      imem_req_valid = (state != BOOT) && (in_use < (CW+1)'(FIFO_DEPTH));
      if (imem_rsp_valid && (drop_cnt != '0)) drop_nxt = drop_cnt - 1'b1;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         drop_nxt  = out_nxt;
         state_nxt = (out_nxt != '0) ? DRAIN : FETCH;
      end else begin
         case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            DRAIN:   if (drop_nxt == '0) state_nxt = FETCH;
            default: state_nxt = BOOT;
         endcase
      end
   end

   // PC tracking and request/drop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_nxt;
         drop_cnt    <= drop_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_keep) resp_pc  <= resp_pc + XLEN'(4);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   // Saturating activity counters; redirects do not clear them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= sat_inc(perf_fetched, pop_fire);
         perf_dropped <= sat_inc(perf_dropped, rsp_drop);
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
